// File: rtl/nandy_pkg.sv
// Shared definitions for the nandy front end: sequencer state encoding and widths.
package nandy_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int INST_W     = 8;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC0 = 2'd1,
        EXEC1 = 2'd2
    } seqState_e;

endpackage

// File: rtl/inst_sequencer_pc_reg.sv
// Program counter register: async reset to RESET_PC, increment or load, load wins.
module pc_reg #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] loadVal,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_r;

    // PC update; a jump load replaces the increment rather than adding to it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (load) begin
            pc_r <= loadVal;
        end else if (inc) begin
            pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: fetches one instruction byte, runs the FETCH/EXEC0/EXEC1
// phases for the control decoder and owns the carry flag and the program counter.
module inst_sequencer
    import nandy_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_pc_sel,
    output logic [ADDR_W-1:0] pc,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [INST_W-1:0] inst,
    output logic              cycle,
    output logic              ncycle,
    output logic              carry,
    output logic              exec_en,
    input  logic              J,
    input  logic              LJ,
    input  logic              MC,
    input  logic              WC,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              alu_carry
);

    seqState_e         state_r, nextState_s;
    logic [INST_W-1:0] inst_r;
    logic              carry_r;
    logic              running_r;
    logic              pcInc_s, pcLoad_s, instLoad_s, carryLoad_s;

    // Holds the bus request low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_r <= 1'b0;
        end else begin
            running_r <= 1'b1;
        end
    end

    // Sequencer state, instruction register and carry flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
            inst_r  <= 8'h00;
            carry_r <= 1'b0;
        end else begin
            state_r <= nextState_s;
            inst_r  <= instLoad_s ? mem_rdata : inst_r;
            carry_r <= carryLoad_s ? alu_carry : carry_r;
        end
    end

    // Next state and commit strobes; J only counts in EXEC1 and LJ only in EXEC0
    always_comb begin
        nextState_s = state_r;
        pcInc_s     = 1'b0;
        pcLoad_s    = 1'b0;
        instLoad_s  = 1'b0;
        carryLoad_s = 1'b0;
        case (state_r)
            FETCH: begin
                if (running_r && mem_ready) begin
                    instLoad_s  = 1'b1;
                    pcInc_s     = 1'b1;
                    nextState_s = EXEC0;
                end else begin
                    nextState_s = FETCH;
                end
            end
            EXEC0: begin
                if (inst_r[7] && MC) begin
                    if (mem_ready) begin
                        carryLoad_s = WC;
                        nextState_s = EXEC1;
                    end else begin
                        nextState_s = EXEC0;
                    end
                end else begin
                    pcLoad_s    = LJ;
                    carryLoad_s = WC;
                    nextState_s = FETCH;
                end
            end
            EXEC1: begin
                pcLoad_s    = J;
                carryLoad_s = WC;
                nextState_s = FETCH;
            end
            default: begin
                nextState_s = FETCH;
            end
        endcase
    end

    // Bus and phase outputs decoded from registered state only
    always_comb begin
        mem_req    = 1'b0;
        mem_pc_sel = 1'b1;
        cycle      = 1'b0;
        exec_en    = 1'b0;
        case (state_r)
            FETCH: begin
                mem_req = running_r;
            end
            EXEC0: begin
                exec_en    = 1'b1;
                mem_req    = running_r & inst_r[7];
                mem_pc_sel = ~inst_r[7];
            end
            EXEC1: begin
                exec_en = 1'b1;
                cycle   = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pcReg (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (pcInc_s),
        .load    (pcLoad_s),
        .loadVal (jump_target),
        .pc      (pc)
    );

    assign inst   = inst_r;
    assign carry  = carry_r;
    assign ncycle = ~cycle;

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Front-end stage directly upstream of the control decoder. Fetches one instruction byte per instruction from the shared memory bus and holds it in the instruction register (`inst`).
- Generates the two-phase `cycle`/`ncycle` signal and owns the carry flag and the program counter.
- Consumes the decoder's J, LJ, MC and WC outputs to sequence instructions. Drives the decoder's `inst`, `cycle`, `ncycle` and `carry` inputs directly.

Parameters:
- ADDR_W, 16, program counter / memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  bus request; high while a fetch or decoder memory cycle is pending.
- mem_pc_sel  out  1  1 = bus address is `pc` (fetch); 0 = address from datapath (MC cycle).
- pc  out  ADDR_W  program counter; used as the fetch address.
- mem_rdata  in  8  read data from the bus.
- mem_ready  in  1  bus completion; data valid and request consumed this cycle.
- inst  out  8  instruction register, to the decoder.
- cycle  out  1  execute phase, to the decoder.
- ncycle  out  1  always ~cycle.
- carry  out  1  carry flag, to the decoder.
- exec_en  out  1  decoder outputs are architecturally effective this cycle.
- J, LJ, MC, WC  in  1 each  decoder outputs.
- jump_target  in  ADDR_W  destination for J/LJ, from the datapath.
- alu_carry  in  1  ALU carry-out.

Behaviour:

Reset (async, rst_n=0):
- State = FETCH.
- pc=RESET_PC; inst=8'h00; cycle=0; carry=0; exec_en=0.
- mem_req=0 while rst_n is low. It rises in the first cycle after deassertion.
- Reset mid-fetch or mid-execute abandons the operation. No bus completion is consumed during reset.

States: FETCH, EXEC0, EXEC1.

FETCH:
- Outputs: mem_req=1, mem_pc_sel=1, exec_en=0, cycle=0.
- If mem_ready: inst<=mem_rdata, pc<=pc+1 (mod 2^ADDR_W; 0xFFFF wraps to 0x0000), go to EXEC0.
- Otherwise hold all state.

EXEC0:
- Outputs: cycle=0, exec_en=1.
- Without MC (inst[7]=0), single-cycle instruction:
  - LJ=1: pc<=jump_target.
  - WC=1: carry<=alu_carry.
  - Next state FETCH.
- With MC (inst[7]=1), memory phase:
  - mem_req=1, mem_pc_sel=0.
  - exec_en stays high, but the datapath commits only on mem_ready.
  - Stay in EXEC0 while mem_ready=0.
  - On mem_ready, go to EXEC1. carry is updated only if WC=1 on that ready cycle.

EXEC1:
- Outputs: cycle=1, mem_req=0, exec_en=1. Lasts exactly one cycle.
- J=1: pc<=jump_target.
- WC=1: carry<=alu_carry.
- Next state FETCH.

General rules:
- inst is stable from the EXEC0 entry until the next FETCH completion.
- Jump priority: the jump target overrides the fetch-time increment. No double increment.
- LJ is ignored in EXEC1; J is ignored in EXEC0. The decoder already qualifies both by cycle. The sequencer re-qualifies so that glitches cannot redirect the PC.
- WC and a jump in the same cycle: both take effect.
- Latency:
  - Single-cycle instruction: 1 fetch + 1 exec = 2 clocks at zero wait states.
  - Memory instruction: 3 clocks at zero wait states.
  - Each wait-state cycle adds 1 clock.
- ncycle is combinationally ~cycle. All other outputs are registered or decoded from state only, with no input-to-output combinational paths.

Decomposition:
- Shared package `nandy_pkg`:
  - State encoding (FETCH=2'd0, EXEC0=2'd1, EXEC1=2'd2).
  - ADDR_W default.
  - INST_W=8 constant.
- One natural sub-module, `pc_reg`: ADDR_W-bit register with async reset to RESET_PC, increment and load inputs, load having priority.
- Everything else lives in `inst_sequencer`.

Test Plan:
1. Reset, then mem_ready=1 constantly, bus returning 8'h45 (non-memory, no jump) -> pc 0,1,2 every 2 clocks; cycle stays 0; exec_en pattern 0,1,0,1.
2. Fetch 8'h90 (inst[7]=1); MC=1; mem_ready low 3 cycles in EXEC0, then high -> cycle=0 for 4 clocks, then cycle=1 for exactly 1 clock; mem_pc_sel=0 during EXEC0.
3. EXEC1 with J=1 and jump_target=16'h1234 -> next fetch address pc=16'h1234, not old pc+1.
4. Fetch with LJ=1 in EXEC0 and jump_target=16'h00F0, WC=1, alu_carry=1 -> pc=16'h00F0 and carry=1 after one clock.
5. pc=16'hFFFF, fetch completes -> pc=16'h0000.
6. rst_n pulsed low mid-EXEC0 while mem_ready is held high -> outputs go to reset values immediately (asynchronously); after release, fetch restarts at RESET_PC with carry=0.
